// File: rtl/lab1_pkg.sv
// ============================================================================
// Module  : lab1_pkg
// Brief   : Shared key-conditioning types and top-level key index constants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lab1_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } key_state_e;

    // Key channel indices as wired into the Lab1 Top start/stop/show inputs.
    localparam int KEY_START = 0;
    localparam int KEY_STOP  = 1;
    localparam int KEY_SHOW  = 2;

    function automatic logic key_is_down(input key_state_e st);
        return (st == PRESSED) || (st == RELEASE_CHK);
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce_ch.sv
// ============================================================================
// Module  : key_debounce_ch
// Brief   : One key channel: synchronizer, debounce FSM, registered level/pulses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);
    import lab1_pkg::*;

    localparam int                 C_CNT_W        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX      = C_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic               C_RELEASED_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_down;

    key_state_e             state_q, state_d;
    logic [C_CNT_W-1:0]     cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= {SYNC_STAGES{C_RELEASED_RAW}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_key_raw};
        end
    end

    assign key_down = sync_q[SYNC_STAGES-1] ^ C_RELEASED_RAW;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (key_down) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!key_down) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_MAX) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + C_CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!key_down) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            RELEASE_CHK: begin
                if (key_down) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_MAX) begin
                    state_d   = RELEASED;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + C_CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
        // Level follows the next state so it moves on the same edge as the pulse.
        level_d = key_is_down(state_d);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;

endmodule

`default_nettype wire

// File: rtl/key_conditioner.sv
// ============================================================================
// Module  : key_conditioner
// Brief   : Array of independent debounced key channels feeding the Lab1 Top.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module key_conditioner #(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_KEYS-1:0] i_key_raw,
    output logic [NUM_KEYS-1:0] o_key_level,
    output logic [NUM_KEYS-1:0] o_key_press,
    output logic [NUM_KEYS-1:0] o_key_release
);
    import lab1_pkg::*;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_key_raw (i_key_raw[k]),
            .o_level   (o_key_level[k]),
            .o_press   (o_key_press[k]),
            .o_release (o_key_release[k])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
// ============================================================================
// Module  : tb_key_conditioner
// Brief   : Directed self-checking bench for key_conditioner (DEBOUNCE_CYCLES=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_conditioner;

    typedef struct {
        string      name;
        logic       rst;
        logic [2:0] raw;
        logic [2:0] lvl;
        logic [2:0] prs;
        logic [2:0] rel;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] raw = 3'b111;
    logic [2:0] lvl, prs, rel;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    key_conditioner #(
        .NUM_KEYS        (3),
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2),
        .ACTIVE_LOW      (1)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_key_raw     (raw),
        .o_key_level   (lvl),
        .o_key_press   (prs),
        .o_key_release (rel)
    );

    always #50 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Drive inputs, take one edge, land 1 unit after it for sampling.
    task automatic step(input logic r, input logic [2:0] k);
        rst = r;
        raw = k;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {level,press,release} got %b required %b", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic r, input logic [2:0] k,
                       input logic [2:0] l, input logic [2:0] p, input logic [2:0] q);
        vec_t v;
        v.name = nm; v.rst = r; v.raw = k; v.lvl = l; v.prs = p; v.rel = q;
        vecs.push_back(v);
    endtask

    task automatic settle();
        for (int i = 0; i < 10; i++) step(1'b0, 3'b111);
    endtask

    int pcnt, rcnt, other, both, pidx;

    initial begin
        // Reset and single-key press/release
        add("reset0", 1'b1, 3'b111, 3'b000, 3'b000, 3'b000);
        add("reset1", 1'b1, 3'b111, 3'b000, 3'b000, 3'b000);
        for (int j = 0; j < 6; j++) add("k0_press_wait", 1'b0, 3'b110, 3'b000, 3'b000, 3'b000);
        add("k0_press", 1'b0, 3'b110, 3'b001, 3'b001, 3'b000);
        for (int j = 0; j < 2; j++) add("k0_hold", 1'b0, 3'b110, 3'b001, 3'b000, 3'b000);
        for (int j = 0; j < 6; j++) add("k0_rel_wait", 1'b0, 3'b111, 3'b001, 3'b000, 3'b000);
        add("k0_release", 1'b0, 3'b111, 3'b000, 3'b000, 3'b001);
        for (int j = 0; j < 2; j++) add("k0_idle", 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);
        // Short glitch on key1
        for (int j = 0; j < 3; j++) add("k1_glitch", 1'b0, 3'b101, 3'b000, 3'b000, 3'b000);
        for (int j = 0; j < 8; j++) add("k1_glitch_after", 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);
        // Simultaneous keys 0 and 2
        for (int j = 0; j < 6; j++) add("k02_press_wait", 1'b0, 3'b010, 3'b000, 3'b000, 3'b000);
        add("k02_press", 1'b0, 3'b010, 3'b101, 3'b101, 3'b000);
        for (int j = 0; j < 2; j++) add("k02_hold", 1'b0, 3'b010, 3'b101, 3'b000, 3'b000);
        for (int j = 0; j < 6; j++) add("k02_rel_wait", 1'b0, 3'b111, 3'b101, 3'b000, 3'b000);
        add("k02_release", 1'b0, 3'b111, 3'b000, 3'b000, 3'b101);
        for (int j = 0; j < 2; j++) add("k02_idle", 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].raw);
            chk(vecs[i].name, {lvl, prs, rel}, {vecs[i].lvl, vecs[i].prs, vecs[i].rel});
        end

        // Bouncing press then stable press on key0
        settle();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, {2'b11, ((i % 2) != 0)});
            chk("bounce_press_quiet", {prs, rel}, 6'b000000);
        end
        for (int e = 0; e < 8; e++) begin
            step(1'b0, 3'b110);
            chk("bounce_press_stable", {lvl, prs, rel},
                {(e >= 6) ? 3'b001 : 3'b000, (e == 6) ? 3'b001 : 3'b000, 3'b000});
        end
        // Bouncing release then stable release on key0
        for (int i = 0; i < 10; i++) begin
            step(1'b0, {2'b11, ((i % 2) == 0)});
            chk("bounce_rel_quiet", {lvl, prs, rel}, 9'b001_000_000);
        end
        for (int e = 0; e < 8; e++) begin
            step(1'b0, 3'b111);
            chk("bounce_rel_stable", {lvl, prs, rel},
                {(e < 6) ? 3'b001 : 3'b000, 3'b000, (e == 6) ? 3'b001 : 3'b000});
        end

        // Reset while key0 is mid-check (cnt=2 after fifth edge), key held throughout
        settle();
        for (int e = 0; e < 5; e++) begin
            step(1'b0, 3'b110);
            chk("rst_mid_pre", {lvl, prs, rel}, 9'b0);
        end
        for (int e = 0; e < 3; e++) begin
            step(1'b1, 3'b110);
            chk("rst_mid_during", {lvl, prs, rel}, 9'b0);
        end
        for (int e = 0; e < 8; e++) begin
            step(1'b0, 3'b110);
            chk("rst_mid_after", {lvl, prs, rel},
                {(e >= 6) ? 3'b001 : 3'b000, (e == 6) ? 3'b001 : 3'b000, 3'b000});
        end

        // Long hold on key2: one press, one release, nothing else
        settle();
        pcnt = 0; rcnt = 0; other = 0; both = 0; pidx = -1;
        for (int e = 0; e < 1000; e++) begin
            step(1'b0, 3'b011);
            if (prs[2]) begin pcnt++; if (pidx < 0) pidx = e; end
            if (rel[2]) rcnt++;
            if ((prs[1:0] != 2'b00) || (rel[1:0] != 2'b00)) other++;
            if ((prs & rel) != 3'b000) both++;
        end
        chk("hold_press_edge", 9'(pidx), 9'd6);
        chk("hold_counts", {1'b0, 4'(pcnt), 4'(rcnt)}, {1'b0, 4'd1, 4'd0});
        chk("hold_level", {lvl, prs, rel}, 9'b100_000_000);
        for (int e = 0; e < 20; e++) begin
            step(1'b0, 3'b111);
            if (prs[2]) pcnt++;
            if (rel[2]) rcnt++;
            if ((prs[1:0] != 2'b00) || (rel[1:0] != 2'b00)) other++;
            if ((prs & rel) != 3'b000) both++;
        end
        chk("hold_final_counts", {1'b0, 4'(pcnt), 4'(rcnt)}, {1'b0, 4'd1, 4'd1});
        chk("hold_no_stray", {1'b0, 4'(other), 4'(both)}, 9'b0);
        chk("hold_final_level", {lvl, prs, rel}, 9'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
